fun_pack: RTL and testbench

//  Transmit side of the control-stream link. Snapshots five 32-bit application words (APP0..APP4).

---
 rtl/fun_pack_pkg.sv | 21 ++
 rtl/fun_pack.sv | 160 ++++++++++++++++
 tb/tb_fun_pack.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fun_pack_pkg.sv
//------------------------------------------------------------------------------
// fun_pack_pkg
// Shared constants and FSM state type for the control-stream transmitter.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fun_pack_pkg;

    localparam int CNTRL_WORDS = 5;
    localparam int IDX_W       = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CNTRL_WORDS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/fun_pack.sv
//------------------------------------------------------------------------------
// fun_pack
// Snapshots APP0..APP4 and sends them as a 5-beat AXI4-Stream packet (APP0
// first, tlast on APP4). Optional macro FUN_PACK_AUTO_SEND_EN: auto-send on change.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fun_pack
    import fun_pack_pkg::*;
#(
    parameter int M_AXIS_CNTRL_TDATA_WIDTH = 32
) (
    input  logic                                  m_axis_cntrl_aclk,
    input  logic                                  m_axis_cntrl_areset,
    input  logic                                  send,
    input  logic [M_AXIS_CNTRL_TDATA_WIDTH-1:0]   APP0_tdata,
    input  logic [M_AXIS_CNTRL_TDATA_WIDTH-1:0]   APP1_tdata,
    input  logic [M_AXIS_CNTRL_TDATA_WIDTH-1:0]   APP2_tdata,
    input  logic [M_AXIS_CNTRL_TDATA_WIDTH-1:0]   APP3_tdata,
    input  logic [M_AXIS_CNTRL_TDATA_WIDTH-1:0]   APP4_tdata,
    output logic                                  m_axis_cntrl_tvalid,
    input  logic                                  m_axis_cntrl_tready,
    output logic [M_AXIS_CNTRL_TDATA_WIDTH-1:0]   m_axis_cntrl_tdata,
    output logic [M_AXIS_CNTRL_TDATA_WIDTH/8-1:0] m_axis_cntrl_tkeep,
    output logic                                  m_axis_cntrl_tlast,
    output logic                                  busy,
    output logic                                  done
);

    localparam int W = M_AXIS_CNTRL_TDATA_WIDTH;

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt, w_idx_inc;
    logic [W-1:0]     r_buf [CNTRL_WORDS];
    logic [W-1:0]     w_app [CNTRL_WORDS];
    logic [W-1:0]     r_tdata, w_tdata_nxt;
    logic             r_tvalid, w_tvalid_nxt;
    logic             r_tlast, w_tlast_nxt;
    logic             r_pending, w_pending_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             w_snap;
    logic             w_hs;
    logic             w_auto_req;

    assign w_app[0] = APP0_tdata;
    assign w_app[1] = APP1_tdata;
    assign w_app[2] = APP2_tdata;
    assign w_app[3] = APP3_tdata;
    assign w_app[4] = APP4_tdata;

    assign w_hs      = r_tvalid & m_axis_cntrl_tready;
    assign w_idx_inc = r_idx + IDX_W'(1);

`ifdef FUN_PACK_AUTO_SEND_EN
    // The snapshot buffer doubles as the record of the last transmitted words.
    always_comb begin
        w_auto_req = 1'b0;
        for (int i = 0; i < CNTRL_WORDS; i++) begin
            if (w_app[i] != r_buf[i]) w_auto_req = 1'b1;
        end
    end
`else
    assign w_auto_req = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_tdata_nxt   = r_tdata;
        w_tvalid_nxt  = r_tvalid;
        w_tlast_nxt   = r_tlast;
        w_pending_nxt = r_pending;
        w_done_nxt    = 1'b0;
        w_snap        = 1'b0;
        case (r_state)
            IDLE: begin
                if (send | w_auto_req) begin
                    w_snap       = 1'b1;
                    w_state_nxt  = SEND;
                    w_idx_nxt    = '0;
                    w_tvalid_nxt = 1'b1;
                    w_tlast_nxt  = 1'b0;
                    w_tdata_nxt  = w_app[0];
                end
            end
            SEND: begin
                if (w_hs && r_idx == LAST_IDX) begin
                    w_done_nxt = 1'b1;
                    if (r_pending | send) begin
                        // Back-to-back restart with inputs as they are right now.
                        w_snap        = 1'b1;
                        w_idx_nxt     = '0;
                        w_tdata_nxt   = w_app[0];
                        w_tlast_nxt   = 1'b0;
                        w_pending_nxt = 1'b0;
                    end else begin
                        w_state_nxt  = IDLE;
                        w_tvalid_nxt = 1'b0;
                        w_tlast_nxt  = 1'b0;
                    end
                end else begin
                    if (w_hs) begin
                        w_idx_nxt   = w_idx_inc;
                        w_tdata_nxt = r_buf[w_idx_inc];
                        w_tlast_nxt = (w_idx_inc == LAST_IDX);
                    end
                    if (send) w_pending_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_tvalid_nxt = 1'b0;
                w_tlast_nxt  = 1'b0;
            end
        endcase
        w_busy_nxt = (w_state_nxt == SEND) | w_pending_nxt;
    end

    always_ff @(posedge m_axis_cntrl_aclk or posedge m_axis_cntrl_areset) begin
        if (m_axis_cntrl_areset) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_tdata   <= '0;
            r_tvalid  <= 1'b0;
            r_tlast   <= 1'b0;
            r_pending <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_tdata   <= w_tdata_nxt;
            r_tvalid  <= w_tvalid_nxt;
            r_tlast   <= w_tlast_nxt;
            r_pending <= w_pending_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_ff @(posedge m_axis_cntrl_aclk or posedge m_axis_cntrl_areset) begin
        if (m_axis_cntrl_areset) begin
            for (int i = 0; i < CNTRL_WORDS; i++) r_buf[i] <= '0;
        end else if (w_snap) begin
            for (int i = 0; i < CNTRL_WORDS; i++) r_buf[i] <= w_app[i];
        end
    end

    assign m_axis_cntrl_tvalid = r_tvalid;
    assign m_axis_cntrl_tdata  = r_tdata;
    assign m_axis_cntrl_tlast  = r_tlast;
    assign m_axis_cntrl_tkeep  = '1;
    assign busy                = r_busy;
    assign done                = r_done;

endmodule

`default_nettype wire

// File: tb/tb_fun_pack.sv
//------------------------------------------------------------------------------
// tb_fun_pack
// Directed self-checking bench for the fun_pack stream transmitter.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fun_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        send;
    logic        tready;
    logic [31:0] app [5];
    logic        tvalid;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        busy;
    logic        done;

    logic [31:0] exp_w   [5];
    logic [31:0] nxt_app [5];
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    fun_pack #(.M_AXIS_CNTRL_TDATA_WIDTH(32)) dut (
        .m_axis_cntrl_aclk   (clk),
        .m_axis_cntrl_areset (rst),
        .send                (send),
        .APP0_tdata          (app[0]),
        .APP1_tdata          (app[1]),
        .APP2_tdata          (app[2]),
        .APP3_tdata          (app[3]),
        .APP4_tdata          (app[4]),
        .m_axis_cntrl_tvalid (tvalid),
        .m_axis_cntrl_tready (tready),
        .m_axis_cntrl_tdata  (tdata),
        .m_axis_cntrl_tkeep  (tkeep),
        .m_axis_cntrl_tlast  (tlast),
        .busy                (busy),
        .done                (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_app(input logic [31:0] base, input logic [31:0] inc);
        for (int i = 0; i < 5; i++) app[i] = base + inc * i;
    endtask

    // Checks five consecutive beats with tready high; optional send pulses and
    // input reloads are applied after the check of beat i.
    task automatic run_beats(input int send_mask, input int load_mask, input bit done0);
        for (int i = 0; i < 5; i++) begin
            chk("beat_tvalid", {31'd0, tvalid}, 32'd1);
            chk("beat_tdata", tdata, exp_w[i]);
            chk("beat_tlast", {31'd0, tlast}, (i == 4) ? 32'd1 : 32'd0);
            chk("beat_busy", {31'd0, busy}, 32'd1);
            chk("beat_done", {31'd0, done}, (i == 0 && done0) ? 32'd1 : 32'd0);
            send = send_mask[i];
            if (load_mask[i]) begin
                for (int j = 0; j < 5; j++) app[j] = nxt_app[j];
            end
            step();
        end
        send = 1'b0;
    endtask

    initial begin
        int          beats;
        int          cyc;
        logic [15:0] pat;

        rst    = 1'b1;
        send   = 1'b0;
        tready = 1'b1;
        set_app(32'h0, 32'h0);
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
        chk("rst_tlast", {31'd0, tlast}, 32'd0);
        chk("rst_tdata", tdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("tkeep", {28'd0, tkeep}, 32'hF);

        // Basic packet, inputs changed mid-packet must not leak in
        set_app(32'h11, 32'h11);
        for (int i = 0; i < 5; i++) exp_w[i] = 32'h11 * (i + 1);
        for (int i = 0; i < 5; i++) nxt_app[i] = 32'hAA + 32'h11 * i;
        send = 1'b1;
        step();
        send = 1'b0;
        run_beats(0, 32'b00100, 1'b0);
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_idle_tvalid", {31'd0, tvalid}, 32'd0);
        chk("t1_idle_tlast", {31'd0, tlast}, 32'd0);
        chk("t1_idle_busy", {31'd0, busy}, 32'd0);
        step();
        chk("t1_done_pulse", {31'd0, done}, 32'd0);
        chk("t1_no_resend", {31'd0, tvalid}, 32'd0);

        // Backpressure: beats held stable while tready is low
        for (int i = 0; i < 5; i++) exp_w[i] = 32'hAA + 32'h11 * i;
        send = 1'b1;
        step();
        send = 1'b0;
        pat   = 16'hB2C9;
        beats = 0;
        cyc   = 0;
        while (beats < 5 && cyc < 40) begin
            chk("bp_tvalid", {31'd0, tvalid}, 32'd1);
            chk("bp_tdata", tdata, exp_w[beats]);
            chk("bp_tlast", {31'd0, tlast}, (beats == 4) ? 32'd1 : 32'd0);
            chk("bp_done", {31'd0, done}, 32'd0);
            tready = pat[cyc % 16];
            step();
            if (tready) beats++;
            cyc++;
        end
        tready = 1'b1;
        chk("bp_beats", beats, 32'd5);
        chk("bp_done_end", {31'd0, done}, 32'd1);
        chk("bp_idle", {31'd0, tvalid}, 32'd0);
        step();

        // Two requests mid-packet collapse to one back-to-back resend using
        // the inputs present at the final handshake
        set_app(32'h01, 32'h01);
        for (int i = 0; i < 5; i++) exp_w[i] = 32'h01 + i;
        for (int i = 0; i < 5; i++) nxt_app[i] = 32'h21 + i;
        send = 1'b1;
        step();
        send = 1'b0;
        run_beats(32'b00110, 32'b01000, 1'b0);
        for (int i = 0; i < 5; i++) exp_w[i] = 32'h21 + i;
        run_beats(0, 0, 1'b1);
        chk("b2b_done", {31'd0, done}, 32'd1);
        chk("b2b_idle", {31'd0, tvalid}, 32'd0);
        chk("b2b_busy", {31'd0, busy}, 32'd0);
        step();
        step();
        chk("b2b_only_one_extra", {31'd0, tvalid}, 32'd0);

        // Asynchronous reset in the middle of a packet
        set_app(32'h31, 32'h01);
        send = 1'b1;
        step();
        send = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("ar_tdata", tdata, 32'h31 + i);
            step();
        end
        rst = 1'b1;
        #1;
        chk("ar_async_tvalid", {31'd0, tvalid}, 32'd0);
        step();
        rst = 1'b0;
        chk("ar_tvalid", {31'd0, tvalid}, 32'd0);
        chk("ar_tlast", {31'd0, tlast}, 32'd0);
        chk("ar_tdata0", tdata, 32'd0);
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_done", {31'd0, done}, 32'd0);
        step();
        set_app(32'h41, 32'h01);
        for (int i = 0; i < 5; i++) exp_w[i] = 32'h41 + i;
        send = 1'b1;
        step();
        send = 1'b0;
        run_beats(0, 0, 1'b0);
        chk("ar_recover_done", {31'd0, done}, 32'd1);
        step();

        // Input change while idle: auto-send only when the feature is built in
        app[2] = 32'h99;
        step();
`ifdef FUN_PACK_AUTO_SEND_EN
        for (int i = 0; i < 5; i++) exp_w[i] = app[i];
        run_beats(0, 0, 1'b0);
        chk("auto_done", {31'd0, done}, 32'd1);
        step();
        step();
        chk("auto_single", {31'd0, tvalid}, 32'd0);
`else
        step();
        chk("noauto_tvalid", {31'd0, tvalid}, 32'd0);
        chk("noauto_busy", {31'd0, busy}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
